vga_grid_renderer: RTL and testbench
====================================

# vga_grid_renderer

Parametrised VGA raster generator for the tic-tac-toe display. It draws a GRID_N×GRID_N board of CELL_W×CELL_H cells with separating grid lines and a highlighted cursor cell. Each cell shows a symbol fetched from an external synchronous sprite memory. It sits between the game-state logic (CONTROL_ARRAY, CURSOR_IDX) and the 1-bit VGA output pins.

## Interface
Parameters:
- H_ACTIVE, 12: visible pixels per line.
- H_FRONT, 1 / H_SYNC, 2 / H_BACK, 1: horizontal porch and sync lengths in pixels.
- V_ACTIVE, 15: visible lines per frame.
- V_FRONT, 1 / V_SYNC, 3 / V_BACK, 2: vertical porch and sync lengths in lines.
- SYNC_POL, 0: active level of HSYNC and VSYNC.
- GRID_N, 3: cells per board side. Valid range 2..8.
- CELL_W, 4 / CELL_H, 5: cell size in pixels.
- LINE_W, 1: grid-line thickness in pixels. Must be less than CELL_W and less than CELL_H.
- ADDR_W, 8: sprite address width. Must satisfy 2^ADDR_W ≥ CELL_W*CELL_H.

Ports:
- CLK, input, 1: pixel clock.
- RESET, input, 1: synchronous, active-high.
- CONTROL_ARRAY, input, 4*GRID_N*GRID_N: one 4-bit code per cell, cell k at [4k+:4]. Cells are numbered row-major from top-left.
- CURSOR_EN, input, 1: enables cursor highlight.
- CURSOR_IDX, input, 6: index of the cursor cell.
- SPRITE_ADDR, output, ADDR_W: cell-local pixel address.
- SPRITE_SEL, output, 1: 0 selects the cross sprite, 1 selects the zero sprite.
- SPRITE_DATA, input, 1: sprite pixel, returned one cycle after SPRITE_ADDR/SPRITE_SEL.
- PIXEL_VALUE, output, 1: output pixel.
- HSYNC / VSYNC, output, 1: sync outputs.
- DE, output, 1: high during active video.
- FRAME_START, output, 1: one-cycle pulse on the output of pixel (0,0).

## Operation
Counters:
- H counter H runs 0..H_TOT-1, where H_TOT = H_ACTIVE+H_FRONT+H_SYNC+H_BACK.
- V counter V increments when H wraps and runs 0..V_TOT-1, where V_TOT = V_ACTIVE+V_FRONT+V_SYNC+V_BACK.
- Counter width is 12 bits.

Cell-local counters:
- lx, col, ly and row are maintained incrementally. No divide or modulo logic.
- lx wraps at CELL_W, which increments col. Both reset when H wraps.
- ly and row behave the same way on line wrap. Both reset when V wraps.

Frame latch:
- CONTROL_ARRAY, CURSOR_EN and CURSOR_IDX are sampled only in the cycle the counters are at (0,0).
- Changes to these inputs during a frame have no effect until the next frame.

Pixel decision, in priority order:
1. Outside the active area, or H ≥ GRID_N*CELL_W, or V ≥ GRID_N*CELL_H: pixel is 0.
2. Grid line (col>0 and lx<LINE_W, or row>0 and ly<LINE_W): pixel is 1.
3. Otherwise, decode the cell code:
   - Code 0 (empty): 0.
   - Code 1 (cross): SPRITE_DATA with SPRITE_SEL=0.
   - Code 2 (zero): SPRITE_DATA with SPRITE_SEL=1.
   - Codes 3..15: 0. SPRITE_SEL is don't-care.
4. If the latched cursor is enabled and cell index row*GRID_N+col equals the latched CURSOR_IDX, the result of step 3 is inverted.
   - A CURSOR_IDX ≥ GRID_N² highlights nothing.

Sprite address and sync:
- SPRITE_ADDR = ly*CELL_W + lx, truncated to ADDR_W bits.
- HSYNC is active while H is in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC-1].
- VSYNC is active while V is in [V_ACTIVE+V_FRONT, V_ACTIVE+V_FRONT+V_SYNC-1], for whole lines.
- DE = (H<H_ACTIVE) and (V<V_ACTIVE).

## Timing
Pipeline, counting from the cycle the counters hold (H,V) as cycle t:
- Stage 1 (t+1): SPRITE_ADDR, SPRITE_SEL, the cell code, the cursor-match flag and the grid/area flags are registered.
- Stage 2 (t+2): SPRITE_DATA is valid and combined with the stage-1 flags.
- Stage 3 (t+3): PIXEL_VALUE, HSYNC, VSYNC, DE and FRAME_START for position (H,V) are registered and visible.
- All outputs share the same 3-cycle latency. No output may lead or lag another.

Reset behaviour:
- While RESET is high: counters, local counters and all pipeline stages clear.
- Reset values: latched codes 0, PIXEL_VALUE 0, DE 0, FRAME_START 0, HSYNC and VSYNC at the inactive level ~SYNC_POL, SPRITE_ADDR 0, SPRITE_SEL 0.
- Mid-frame reset takes effect on the next edge. No partial line completes.
- The first cycle after release has counters at (0,0) and latches the controls. FRAME_START pulses 3 cycles later.

Periods:
- Line period is exactly H_TOT cycles. Frame period is exactly H_TOT*V_TOT cycles.

## Test plan
All scenarios use defaults: H_TOT=16, V_TOT=21, frame of 336 cycles.

1. Release RESET → FRAME_START pulses 3 cycles after release, then every 336 cycles. HSYNC is low for output columns 13–14 of every line. VSYNC is low for lines 16–18. DE is high only for columns 0–11 of lines 0–14.
2. All codes = 1; the sprite model returns SPRITE_ADDR[0] one cycle later → in cell 0, SPRITE_ADDR runs 0..19 and SPRITE_SEL=0. Off-line pixels equal address parity. Columns 4, 8 and lines 5, 10 are 1. Columns 12–15 and lines 15–20 are 0.
3. All codes = 2 latched; at line 7, switch all codes to 1 → SPRITE_SEL stays 1 for the rest of the frame and becomes 0 from the next FRAME_START.
4. All codes = 0, CURSOR_EN=1, CURSOR_IDX=4 → pixels at H 5–7, V 6–9 are 1. All other non-grid-line pixels are 0. With CURSOR_IDX=9, no cell is highlighted.
5. Assert RESET for one cycle at V=10, H=6 → the next cycle shows DE=0, PIXEL_VALUE=0 and inactive syncs. FRAME_START follows 3 cycles after release, with no extra or missing line.
6. Cell 8 code = 7, sprite model returns 1 → cell 8 interior pixels are 0. With cursor on cell 8, they are 1.

Source files
------------

// File: rtl/vga_grid_renderer.sv
// vga_grid_renderer
//   Draws a GRID_N x GRID_N tic-tac-toe board on a 1-bit VGA raster. The board
//   has grid lines between cells and can highlight one cursor cell. Each cell's
//   symbol comes from an external synchronous sprite memory that has one cycle
//   of read latency.
// Ports
//   CLK, RESET          pixel clock, synchronous active-high reset
//   CONTROL_ARRAY       4-bit code per cell, cell k at [4k+:4], row-major
//   CURSOR_EN/IDX       cursor highlight enable and cell index
//   SPRITE_ADDR/SEL     cell-local pixel address and sprite select (0 cross, 1 zero)
//   SPRITE_DATA         sprite pixel, valid one cycle after SPRITE_ADDR/SEL
//   PIXEL_VALUE         output pixel
//   HSYNC/VSYNC/DE      video timing outputs
//   FRAME_START         pulse coincident with output pixel (0,0)
//   Every video output has the same 3-cycle latency from the raster counters.
module vga_grid_renderer #(
  parameter int   H_ACTIVE = 12,
  parameter int   H_FRONT  = 1,
  parameter int   H_SYNC   = 2,
  parameter int   H_BACK   = 1,
  parameter int   V_ACTIVE = 15,
  parameter int   V_FRONT  = 1,
  parameter int   V_SYNC   = 3,
  parameter int   V_BACK   = 2,
  parameter logic SYNC_POL = 1'b0,
  parameter int   GRID_N   = 3,
  parameter int   CELL_W   = 4,
  parameter int   CELL_H   = 5,
  parameter int   LINE_W   = 1,
  parameter int   ADDR_W   = 8
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic [4*GRID_N*GRID_N-1:0]   CONTROL_ARRAY,
  input  logic                         CURSOR_EN,
  input  logic [5:0]                   CURSOR_IDX,
  output logic [ADDR_W-1:0]            SPRITE_ADDR,
  output logic                         SPRITE_SEL,
  input  logic                         SPRITE_DATA,
  output logic                         PIXEL_VALUE,
  output logic                         HSYNC,
  output logic                         VSYNC,
  output logic                         DE,
  output logic                         FRAME_START
);
  localparam logic [11:0] H_LAST   = 12'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [11:0] V_LAST   = 12'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [11:0] HS_BEG   = 12'(H_ACTIVE + H_FRONT);
  localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [11:0] VS_BEG   = 12'(V_ACTIVE + V_FRONT);
  localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FRONT + V_SYNC - 1);
  localparam logic [11:0] H_ACT12  = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT12  = 12'(V_ACTIVE);
  localparam logic [11:0] GRID_WPX = 12'(GRID_N * CELL_W);
  localparam logic [11:0] GRID_HPX = 12'(GRID_N * CELL_H);
  localparam logic [11:0] CW_LAST  = 12'(CELL_W - 1);
  localparam logic [11:0] CH_LAST  = 12'(CELL_H - 1);
  localparam logic [11:0] LW12     = 12'(LINE_W);
  localparam int          CTRL_W   = 4 * GRID_N * GRID_N;

  // Raster and cell-local counters
  logic [11:0] h_q, h_d, v_q, v_d;
  logic [11:0] lx_q, lx_d, col_q, col_d, ly_q, ly_d, row_q, row_d;

  always_comb begin
    h_d   = h_q + 12'd1;
    v_d   = v_q;
    lx_d  = lx_q + 12'd1;
    col_d = col_q;
    ly_d  = ly_q;
    row_d = row_q;
    if (lx_q == CW_LAST) begin
      lx_d  = '0;
      col_d = col_q + 12'd1;
    end
    if (h_q == H_LAST) begin
      h_d   = '0;
      lx_d  = '0;
      col_d = '0;
      v_d   = v_q + 12'd1;
      if (ly_q == CH_LAST) begin
        ly_d  = '0;
        row_d = row_q + 12'd1;
      end else begin
        ly_d  = ly_q + 12'd1;
      end
      if (v_q == V_LAST) begin
        v_d   = '0;
        ly_d  = '0;
        row_d = '0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      h_q <= '0; v_q <= '0; lx_q <= '0; col_q <= '0; ly_q <= '0; row_q <= '0;
    end else begin
      h_q <= h_d; v_q <= v_d; lx_q <= lx_d; col_q <= col_d; ly_q <= ly_d; row_q <= row_d;
    end
  end

  // Frame latch. Pixel (0,0) is decided in the same cycle that the latch
  // loads, so that cycle reads the live inputs directly. This keeps the
  // whole frame consistent.
  logic              at_origin;
  logic [CTRL_W-1:0] ctrl_q, ctrl_eff;
  logic              cur_en_q, cur_en_eff;
  logic [5:0]        cur_idx_q, cur_idx_eff;

  assign at_origin   = (h_q == '0) && (v_q == '0);
  assign ctrl_eff    = at_origin ? CONTROL_ARRAY : ctrl_q;
  assign cur_en_eff  = at_origin ? CURSOR_EN     : cur_en_q;
  assign cur_idx_eff = at_origin ? CURSOR_IDX    : cur_idx_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ctrl_q <= '0; cur_en_q <= 1'b0; cur_idx_q <= '0;
    end else if (at_origin) begin
      ctrl_q <= CONTROL_ARRAY; cur_en_q <= CURSOR_EN; cur_idx_q <= CURSOR_IDX;
    end
  end

  // Stage-0 decode. Inside the board, row and col are below GRID_N <= 8, so
  // 3 bits of each are enough. Outside the board the area flag masks the result.
  logic [6:0]        cell_idx;
  logic [3:0]        code_c;
  logic              area_c, grid_c, cur_c;
  logic [ADDR_W-1:0] addr_c;

  assign cell_idx = 7'(row_q[2:0]) * 7'(GRID_N) + 7'(col_q[2:0]);

  always_comb begin
    code_c = 4'd0;
    for (int k = 0; k < GRID_N * GRID_N; k++)
      if (cell_idx == 7'(k)) code_c = ctrl_eff[4*k +: 4];
  end

  assign area_c = (h_q < H_ACT12) && (v_q < V_ACT12) && (h_q < GRID_WPX) && (v_q < GRID_HPX);
  assign grid_c = ((col_q != '0) && (lx_q < LW12)) || ((row_q != '0) && (ly_q < LW12));
  // An out-of-range CURSOR_IDX cannot match, because in-board cell_idx < GRID_N^2.
  assign cur_c  = cur_en_eff && ({1'b0, cur_idx_eff} == cell_idx);
  assign addr_c = ADDR_W'(ly_q) * ADDR_W'(CELL_W) + ADDR_W'(lx_q);

  // Timing flags are carried as "active" bits: {hs, vs, de, fs}.
  logic [3:0] tim_c;
  assign tim_c = {(h_q >= HS_BEG) && (h_q <= HS_END),
                  (v_q >= VS_BEG) && (v_q <= VS_END),
                  (h_q < H_ACT12) && (v_q < V_ACT12),
                  at_origin};

  // Stage 1: the sprite request goes out here.
  logic       s1_sym_q, s1_cur_q, s1_grid_q, s1_area_q;
  logic [3:0] s1_tim_q;
  // Stage 2: the sprite data returns here.
  logic       s2_sym_q, s2_cur_q, s2_grid_q, s2_area_q;
  logic [3:0] s2_tim_q;
  logic       pix_d;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      SPRITE_ADDR <= '0; SPRITE_SEL <= 1'b0;
      s1_sym_q <= 1'b0; s1_cur_q <= 1'b0; s1_grid_q <= 1'b0; s1_area_q <= 1'b0; s1_tim_q <= '0;
      s2_sym_q <= 1'b0; s2_cur_q <= 1'b0; s2_grid_q <= 1'b0; s2_area_q <= 1'b0; s2_tim_q <= '0;
    end else begin
      SPRITE_ADDR <= addr_c;
      SPRITE_SEL  <= (code_c == 4'd2);
      s1_sym_q    <= (code_c == 4'd1) || (code_c == 4'd2);
      s1_cur_q    <= cur_c;
      s1_grid_q   <= grid_c;
      s1_area_q   <= area_c;
      s1_tim_q    <= tim_c;
      s2_sym_q    <= s1_sym_q;
      s2_cur_q    <= s1_cur_q;
      s2_grid_q   <= s1_grid_q;
      s2_area_q   <= s1_area_q;
      s2_tim_q    <= s1_tim_q;
    end
  end

  // Grid lines take priority over the cursor inversion. Only the cell content is inverted.
  always_comb begin
    pix_d = 1'b0;
    if (s2_area_q) pix_d = s2_grid_q ? 1'b1 : ((s2_sym_q & SPRITE_DATA) ^ s2_cur_q);
  end

  // Stage 3: outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      PIXEL_VALUE <= 1'b0; HSYNC <= ~SYNC_POL; VSYNC <= ~SYNC_POL; DE <= 1'b0; FRAME_START <= 1'b0;
    end else begin
      PIXEL_VALUE <= pix_d;
      HSYNC       <= s2_tim_q[3] ? SYNC_POL : ~SYNC_POL;
      VSYNC       <= s2_tim_q[2] ? SYNC_POL : ~SYNC_POL;
      DE          <= s2_tim_q[1];
      FRAME_START <= s2_tim_q[0];
    end
  end
endmodule

// File: tb/tb_vga_grid_renderer.sv
module tb_vga_grid_renderer;
  localparam int HT = 16, VT = 21, HA = 12, VA = 15, GN = 3, CW = 4, CH = 5, LW = 1;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [35:0] CONTROL_ARRAY = '0;
  logic        CURSOR_EN = 1'b0;
  logic [5:0]  CURSOR_IDX = '0;
  logic [7:0]  SPRITE_ADDR;
  logic        SPRITE_SEL;
  logic        SPRITE_DATA = 1'b0;
  logic        PIXEL_VALUE, HSYNC, VSYNC, DE, FRAME_START;

  vga_grid_renderer dut (
    .CLK(CLK), .RESET(RESET), .CONTROL_ARRAY(CONTROL_ARRAY), .CURSOR_EN(CURSOR_EN),
    .CURSOR_IDX(CURSOR_IDX), .SPRITE_ADDR(SPRITE_ADDR), .SPRITE_SEL(SPRITE_SEL),
    .SPRITE_DATA(SPRITE_DATA), .PIXEL_VALUE(PIXEL_VALUE), .HSYNC(HSYNC), .VSYNC(VSYNC),
    .DE(DE), .FRAME_START(FRAME_START));

  always #5 CLK = ~CLK;

  // Synchronous sprite memory with random contents.
  bit rom [0:1][0:255];
  always @(posedge CLK) SPRITE_DATA <= rom[SPRITE_SEL][SPRITE_ADDR];

  int checks = 0, failures = 0;

  // Reference model. Record layout: {pix, hsync, vsync, de, frame_start}.
  localparam logic [4:0] RST_REC = 5'b01100;
  int          mh, mv;
  logic [35:0] l_ctrl;
  bit          l_en;
  int          l_idx;
  logic [4:0]  pipe0, pipe1, outr;

  function automatic logic [4:0] rec(input int h, input int v);
    int lx, col, ly, row, code;
    bit area, pix, hs, vs, de, fs;
    lx = h % CW; col = h / CW; ly = v % CH; row = v / CH;
    area = (h < HA) && (v < VA) && (h < GN*CW) && (v < GN*CH);
    pix = 1'b0;
    if (area) begin
      if ((col > 0 && lx < LW) || (row > 0 && ly < LW)) pix = 1'b1;
      else begin
        code = int'(l_ctrl[4*(row*GN+col) +: 4]);
        if (code == 1) pix = rom[0][ly*CW+lx];
        else if (code == 2) pix = rom[1][ly*CW+lx];
        if (l_en && l_idx == row*GN+col) pix = ~pix;
      end
    end
    hs = !(h >= HA+1 && h <= HA+2);   // active-low sync
    vs = !(v >= VA+1 && v <= VA+3);
    de = (h < HA) && (v < VA);
    fs = (h == 0) && (v == 0);
    return {pix, hs, vs, de, fs};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s at h=%0d v=%0d observed=%0h expected=%0h", tag, mh, mv, obs, exp);
    end
  endtask

  // Advance one clock edge, updating the model with the inputs as they stand, then check.
  task automatic step();
    int ea, es;
    ea = -1; es = -1;
    if (RESET) begin
      pipe0 = RST_REC; pipe1 = RST_REC; outr = RST_REC;
      ea = 0; es = 0;
      mh = 0; mv = 0;
    end else begin
      int lx, col, ly, row, code;
      if (mh == 0 && mv == 0) begin
        l_ctrl = CONTROL_ARRAY; l_en = CURSOR_EN; l_idx = int'(CURSOR_IDX);
      end
      outr = pipe1; pipe1 = pipe0; pipe0 = rec(mh, mv);
      lx = mh % CW; col = mh / CW; ly = mv % CH; row = mv / CH;
      if (mh < HA && mv < VA && mh < GN*CW && mv < GN*CH) begin
        ea = ly*CW + lx;
        code = int'(l_ctrl[4*(row*GN+col) +: 4]);
        if (code == 1) es = 0;
        else if (code == 2) es = 1;
      end
      mh = mh + 1;
      if (mh == HT) begin
        mh = 0; mv = (mv + 1) % VT;
      end
    end
    @(posedge CLK); #1;
    chk("video_out", 32'({PIXEL_VALUE, HSYNC, VSYNC, DE, FRAME_START}), 32'(outr));
    if (ea >= 0) chk("sprite_addr", 32'(SPRITE_ADDR), 32'(ea));
    if (es >= 0) chk("sprite_sel", 32'(SPRITE_SEL), 32'(es));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // The model position always advances, so this bound only guards against misuse.
  task automatic run_until(input int h, input int v);
    for (int n = 0; n < 2*HT*VT && !(mh == h && mv == v); n++) step();
  endtask

  task automatic set_all(input logic [3:0] c);
    for (int k = 0; k < 9; k++) CONTROL_ARRAY[4*k +: 4] = c;
  endtask

  task automatic set_random();
    for (int k = 0; k < 9; k++)
      CONTROL_ARRAY[4*k +: 4] = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(3, 15))
                                                             : 4'($urandom_range(0, 2));
    CURSOR_EN  = 1'($urandom_range(0, 1));
    CURSOR_IDX = 6'($urandom_range(0, 10));
  endtask

  initial begin
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 256; j++) rom[i][j] = 1'($urandom_range(0, 1));
    l_ctrl = '0; l_en = 1'b0; l_idx = 0; mh = 0; mv = 0;

    // Reset state.
    RESET = 1'b1;
    run(3);
    // Release with crosses everywhere and no cursor.
    RESET = 1'b0; set_all(4'd1);
    run(2*HT*VT);
    // Latch a frame of zeros, then switch the codes at line 7. The switch only applies from the next frame.
    set_all(4'd2);
    run_until(0, 0);
    step();
    run_until(0, 7);
    set_all(4'd1);
    run(HT*VT + 20);
    // Empty board with the cursor on cell 4, then an out-of-range cursor.
    set_all(4'd0); CURSOR_EN = 1'b1; CURSOR_IDX = 6'd4;
    run_until(0, 0); run(HT*VT);
    CURSOR_IDX = 6'd9;
    run(HT*VT);
    // Randomized frames, with some inputs changed mid-frame.
    for (int f = 0; f < 4; f++) begin
      set_random();
      run($urandom_range(50, 330));
      set_random();
      run_until(0, 0);
    end
    // Mid-frame reset at V=10, H=6.
    set_random();
    run_until(6, 10);
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    run(HT*VT + 10);
    // Invalid code 7 in cell 8. The cursor is off first, then on.
    set_random(); CONTROL_ARRAY[35:32] = 4'd7; CURSOR_EN = 1'b0; CURSOR_IDX = 6'd8;
    for (int j = 0; j < 256; j++) begin rom[0][j] = 1'b1; rom[1][j] = 1'b1; end
    run_until(0, 0); run(HT*VT);
    CURSOR_EN = 1'b1;
    run(HT*VT + 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
